gfx_planar_fetch: RTL and testbench

Parametrised successor to the RX-78 combinational pixel composer. It owns VRAM fetch for an N-plane foreground layer and an N-plane background layer: each 8-pixel group is prefetched one group ahead through a read-request state machine, the bytes are double-buffered, and the pixel is composed through the six-entry palette scheme into registered 8-bit RGB. It sits between the video timing generator and the VRAM port, and feeds the MiSTer video output path.

---
 rtl/gfx_planar_fetch_if.sv | 38 +++
 rtl/gfx_planar_fetch.sv | 137 +++++++++++++
 tb/tb_gfx_planar_fetch.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/gfx_planar_fetch_if.sv
// Pixel-timing, VRAM read and RGB output bundle of gfx_planar_fetch.
// GFX_BORDER_EN adds the border colour input.
interface gfx_planar_fetch_if #(
    parameter int PLANES  = 3,
    parameter int VRAM_AW = 16
);
    logic                  ce_pix;
    logic [8:0]            h;
    logic [8:0]            v;
    logic                  vram_rd;
    logic [VRAM_AW-1:0]    vram_addr;
    logic [7:0]            vram_data;
    logic [16*PLANES-1:0]  pal;
    logic [2*PLANES-1:0]   mask;
    logic [7:0]            red;
    logic [7:0]            green;
    logic [7:0]            blue;
    logic                  de_out;
`ifdef GFX_BORDER_EN
    logic [7:0]            border;
`endif

    modport master (
`ifdef GFX_BORDER_EN
        output border,
`endif
        output ce_pix, h, v, vram_data, pal, mask,
        input  vram_rd, vram_addr, red, green, blue, de_out
    );

    modport slave (
`ifdef GFX_BORDER_EN
        input  border,
`endif
        input  ce_pix, h, v, vram_data, pal, mask,
        output vram_rd, vram_addr, red, green, blue, de_out
    );
endinterface

// File: rtl/gfx_planar_fetch.sv
// Planar fg/bg VRAM prefetch (one group ahead), double-buffered bytes, palette compose.
// Optional GFX_BORDER_EN: border colour decoded outside the active area.
module gfx_planar_fetch #(
    parameter int          PLANES       = 3,
    parameter int          LINE_BYTES   = 24,
    parameter int          LINES        = 184,
    parameter logic [15:0] PLANE_STRIDE = 16'h1C00,
    parameter int          VRAM_AW      = 16
) (
    input logic clk,
    input logic reset,
    gfx_planar_fetch_if.slave bus
);
    localparam int NP = 2 * PLANES;
    localparam int KW = $clog2(NP + 1);

    typedef enum logic [1:0] {IDLE, REQ, LAST} state_t;

    state_t                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [VRAM_AW-1:0]     addr_q, addr_d;
    logic [NP-1:0][7:0]     hold_q, hold_d;
    logic [NP-1:0][7:0]     cur_q, cur_d;
    logic                   clr_q, clr_d;
    logic [23:0]            rgb_q, rgb_d;
    logic                   de_q, de_d;

    logic [5:0]             col;
    logic [9:0]             row;
    logic                   in_grp, grp_start, load, active;
    logic [VRAM_AW-1:0]     base;
    logic [7:0]             c_fg, c_bg;
    logic [23:0]            pix_rgb, bord_rgb;

    function automatic logic [7:0] dec(input logic [7:0] c, input int i);
        return c[4+i] ? (c[i] ? 8'hFF : 8'h80) : 8'h00;
    endfunction

    // The group being fetched is the one after the pixel currently shown
    assign col       = bus.h[8:3] + 6'd1;
    assign row       = (col == 6'd0) ? {1'b0, bus.v} + 10'd1 : {1'b0, bus.v};
    assign in_grp    = (32'(col) < LINE_BYTES) && (32'(row) < LINES);
    assign grp_start = bus.ce_pix && (bus.h[2:0] == 3'd0);
    assign load      = bus.ce_pix && (bus.h[2:0] == 3'd7);
    assign active    = (32'(bus.h) < 8 * LINE_BYTES) && (32'(bus.v) < LINES);
    assign base      = VRAM_AW'(32'(row) * LINE_BYTES + 32'(col));

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        addr_d        = addr_q;
        hold_d        = hold_q;
        cur_d         = cur_q;
        clr_d         = clr_q;
        bus.vram_rd   = 1'b0;
        bus.vram_addr = '0;
        case (state_q)
            IDLE: if (grp_start && in_grp) begin
                state_d = REQ;
                k_d     = '0;
                addr_d  = base;
            end
            REQ: begin
                bus.vram_rd   = 1'b1;
                bus.vram_addr = addr_q;
                addr_d        = addr_q + VRAM_AW'(PLANE_STRIDE);
                k_d           = k_q + KW'(1);
                // Data for the previous request arrives now
                if (k_q != '0) hold_d[k_q - KW'(1)] = bus.vram_data;
                if (k_q == KW'(NP - 1)) state_d = LAST;
            end
            LAST: begin
                hold_d[NP-1] = bus.vram_data;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Latest group decides whether the coming load shows blank
        if (grp_start) clr_d = !in_grp;
        if (load) begin
            cur_d = clr_q ? '0 : hold_q;
            if (clr_q) hold_d = '0;
        end
    end

    always_comb begin
        c_fg = '0;
        c_bg = '0;
        for (int k = 0; k < NP; k++) begin
            if (bus.mask[k] && cur_q[k][bus.h[2:0]]) begin
                if (k < PLANES) c_fg = c_fg | bus.pal[8*k +: 8];
                else            c_bg = c_bg | bus.pal[8*k +: 8];
            end
        end
        pix_rgb  = '0;
        bord_rgb = '0;
        for (int i = 0; i < 3; i++) begin
            pix_rgb[8*(2-i) +: 8] = (dec(c_fg, i) != 8'h00) ? dec(c_fg, i) : dec(c_bg, i);
`ifdef GFX_BORDER_EN
            bord_rgb[8*(2-i) +: 8] = dec(bus.border, i);
`endif
        end
        rgb_d = rgb_q;
        de_d  = de_q;
        if (bus.ce_pix) begin
            de_d  = active;
            rgb_d = active ? pix_rgb : bord_rgb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            addr_q  <= '0;
            hold_q  <= '0;
            cur_q   <= '0;
            clr_q   <= 1'b0;
            rgb_q   <= '0;
            de_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
            cur_q   <= cur_d;
            clr_q   <= clr_d;
            rgb_q   <= rgb_d;
            de_q    <= de_d;
        end
    end

    assign bus.red    = rgb_q[23:16];
    assign bus.green  = rgb_q[15:8];
    assign bus.blue   = rgb_q[7:0];
    assign bus.de_out = de_q;
endmodule

// File: tb/tb_gfx_planar_fetch.sv
// Self-checking bench for gfx_planar_fetch: VRAM model, table vectors, reset/fetch sequences, random lines.
module tb_gfx_planar_fetch;
    localparam int P      = 3;
    localparam int NP     = 2 * P;
    localparam int LB     = 24;
    localparam int LINES  = 184;
    localparam int STRIDE = 'h1C00;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gfx_planar_fetch_if #(.PLANES(P), .VRAM_AW(16)) bus();
    gfx_planar_fetch #(.PLANES(P), .LINE_BYTES(LB), .LINES(LINES),
                       .PLANE_STRIDE(16'h1C00), .VRAM_AW(16))
        dut (.clk(clk), .reset(reset), .bus(bus));

    logic [7:0] mem [0:65535];
    always @(posedge clk) bus.vram_data <= mem[bus.vram_addr];

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_en = 1'b0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [47:0] bytes;
        logic [47:0] pal;
        logic [5:0]  mask;
        int          px;
        logic [23:0] rgb;
    } vec_t;
    vec_t tv[8];

    function automatic logic [7:0] dec(input logic [7:0] c, input int i);
        return c[4+i] ? (c[i] ? 8'hFF : 8'h80) : 8'h00;
    endfunction

    function automatic logic [24:0] model(input int hh, input int vv);
        logic [7:0]  cf, cb, f, b;
        logic [23:0] rgb;
        int          a;
        cf = 0; cb = 0; rgb = 0;
        if (hh < 8 * LB && vv < LINES) begin
            for (int k = 0; k < NP; k++) begin
                a = (k * STRIDE + vv * LB + hh / 8) & 'hFFFF;
                if (bus.mask[k] && mem[a][hh % 8]) begin
                    if (k < P) cf = cf | bus.pal[8*k +: 8];
                    else       cb = cb | bus.pal[8*k +: 8];
                end
            end
            for (int i = 0; i < 3; i++) begin
                f = dec(cf, i); b = dec(cb, i);
                rgb[8*(2-i) +: 8] = (f != 0) ? f : b;
            end
            return {rgb, 1'b1};
        end
`ifdef GFX_BORDER_EN
        return {dec(bus.border, 0), dec(bus.border, 1), dec(bus.border, 2), 1'b0};
`else
        return 25'd0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        logic [15:0] a;
        @(negedge clk);
        if (chk_en && bus.vram_rd) begin
            if (exp_q.size() == 0) check("vram_rd_unexpected", {16'd0, bus.vram_addr}, 32'hFFFFFFFF);
            else begin
                a = exp_q.pop_front();
                check("vram_addr", {16'd0, bus.vram_addr}, {16'd0, a});
            end
        end
    endtask

    task automatic step(input int hh, input int vv, input bit chk);
        int col, row;
        bus.h = 9'(hh); bus.v = 9'(vv); bus.ce_pix = 1'b1;
        if (hh % 8 == 0) begin
            col = (hh / 8 + 1) % 64;
            row = (col == 0) ? vv + 1 : vv;
            if (col < LB && row < LINES)
                for (int k = 0; k < NP; k++) exp_q.push_back(16'(k * STRIDE + row * LB + col));
        end
        tick();
        bus.ce_pix = 1'b0;
        if (chk) check($sformatf("pix h=%0d v=%0d", hh, vv),
                       {7'd0, bus.red, bus.green, bus.blue, bus.de_out}, {7'd0, model(hh, vv)});
        repeat ($urandom_range(1, 2)) tick();
    endtask

    initial begin
        logic [15:0] req_a[6];
        int          rd_cnt, vv;
        req_a = '{16'h00F2, 16'h1CF2, 16'h38F2, 16'h54F2, 16'h70F2, 16'h8CF2};
        tv[0] = '{48'h000000000001, 48'h000000000011, 6'h3F, 0, 24'hFF0000};
        tv[1] = '{48'h000000000001, 48'h000000000011, 6'h3F, 1, 24'h000000};
        tv[2] = '{48'h000001000001, 48'h000066000010, 6'h3F, 0, 24'h80FFFF};
        tv[3] = '{48'h000000000001, 48'h000000000011, 6'h3E, 0, 24'h000000};
        tv[4] = '{48'h000000000101, 48'h000000000110, 6'h3F, 0, 24'hFF0000};
        tv[5] = '{48'h040000000004, 48'h200000000007, 6'h3F, 2, 24'h008000};
        tv[6] = '{48'h000200000002, 48'h007700000070, 6'h3F, 1, 24'h808080};
        tv[7] = '{48'h000000008000, 48'h000000007700, 6'h3F, 7, 24'hFFFFFF};
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        reset = 1'b1; bus.ce_pix = 1'b0; bus.h = '0; bus.v = '0;
        bus.pal = '0; bus.mask = '0;
`ifdef GFX_BORDER_EN
        bus.border = 8'h00;
`endif
        repeat (3) tick();
        check("reset_outputs", {6'd0, bus.vram_rd, bus.vram_addr, bus.red, bus.de_out}, 32'd0);
        check("reset_gb", {16'd0, bus.green, bus.blue}, 32'd0);
        reset = 1'b0;
        tick();
        chk_en = 1'b1;

        // Table vectors: group col 5 of line 20, fetched at h=32
        foreach (tv[i]) begin
            for (int k = 0; k < NP; k++) mem[k * STRIDE + 20 * LB + 5] = tv[i].bytes[8*k +: 8];
            bus.pal = tv[i].pal; bus.mask = tv[i].mask;
            for (int hh = 32; hh < 48; hh++) begin
                step(hh, 20, hh >= 40);
                if (hh == 40 + tv[i].px)
                    check($sformatf("vec%0d", i), {8'd0, bus.red, bus.green, bus.blue}, {8'd0, tv[i].rgb});
            end
        end

        // Reset while the third request (k=2) is on the bus
        chk_en = 1'b0;
        bus.h = 9'd8; bus.v = 9'd10; bus.ce_pix = 1'b1;
        tick();
        bus.ce_pix = 1'b0;
        check("rst_k0_addr", {15'd0, bus.vram_rd, bus.vram_addr}, {15'd0, 1'b1, 16'h00F2});
        tick(); tick();
        check("rst_k2_addr", {15'd0, bus.vram_rd, bus.vram_addr}, {15'd0, 1'b1, 16'h38F2});
        check("pre_rst_de", {31'd0, bus.de_out}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_rd_drop", {15'd0, bus.vram_rd, bus.vram_addr}, 32'd0);
        check("rst_rgb_de", {7'd0, bus.red, bus.green, bus.blue, bus.de_out}, 32'd0);
        tick();

        // Clean fetch after reset: six addresses in plane order, then idle
        bus.h = 9'd8; bus.v = 9'd10; bus.ce_pix = 1'b1;
        tick();
        bus.ce_pix = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("fetch_addr%0d", i), {15'd0, bus.vram_rd, bus.vram_addr}, {15'd0, 1'b1, req_a[i]});
            tick();
        end
        check("fetch_rd_end", {31'd0, bus.vram_rd}, 32'd0);
        tick();
        exp_q.delete();
        chk_en = 1'b1;

        // Group at col == LINE_BYTES: no read at all
        bus.h = 9'(8 * (LB - 1)); bus.v = 9'd10; bus.ce_pix = 1'b1;
        rd_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            bus.ce_pix = 1'b0;
            if (bus.vram_rd) rd_cnt++;
        end
        check("col_lb_no_rd", rd_cnt, 0);
`ifdef GFX_BORDER_EN
        bus.border = 8'h40;
        step(200, 10, 1'b1);
        check("border_rgb_de", {7'd0, bus.red, bus.green, bus.blue, bus.de_out}, {7'd0, 24'h000080, 1'b0});
`else
        step(200, 10, 1'b1);
        check("outside_rgb_de", {7'd0, bus.red, bus.green, bus.blue, bus.de_out}, 32'd0);
`endif

        // Random lines, including the last active line and the first inactive one
        for (int n = 0; n < 7; n++) begin
            vv = (n == 0) ? LINES - 1 : (n == 1) ? LINES : $urandom_range(1, LINES - 1);
            bus.pal  = {$urandom, $urandom};
            bus.mask = (n == 2) ? 6'h3F : 6'($urandom);
`ifdef GFX_BORDER_EN
            bus.border = 8'($urandom);
`endif
            for (int c = 0; c < LB; c++)
                for (int k = 0; k < NP; k++) mem[(k * STRIDE + vv * LB + c) & 'hFFFF] = 8'($urandom);
            for (int hh = 504; hh < 512; hh++) step(hh, vv - 1, 1'b1);
            for (int hh = 0; hh < 8 * LB + 16; hh++) step(hh, vv, 1'b1);
        end
        repeat (10) tick();
        check("addr_queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
